// File: rtl/dg0045_io_scanner.sv
// dg0045_io_scanner
//
// Peripheral stage that sits between the DG0045 core's nL[3:0]/ND pins and its
// KIN[3:0] input. It has three jobs:
//   * Capture: every rising edge of the (synchronised) ND strobe stores the
//     current L value (the inverse of the nL pins) into a 4-entry circular
//     digit buffer. The same value is also kept as the last L value.
//   * Scan: a prescaler divides each digit slot into SCAN_DIV clocks and steps
//     a slot index 0..3. The first BLANK clocks of every slot drive no digit,
//     which suppresses ghosting. The digit selects double as keypad column
//     drives.
//   * Keys: at the last clock of each slot, the synchronised keypad rows are
//     sampled for the column that is being driven. A row pattern must be
//     sampled DEBOUNCE times in a row before it becomes that column's debounced
//     state. kin returns the debounced rows of the column that bits [1:0] of
//     the last L value address.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   nd_n       in   1  core ND strobe, active-low, asynchronous
//   nl_n       in   4  core nL[3:0] (inverted L register), asynchronous
//   key_row    in   4  keypad row sense, 1 = pressed, asynchronous
//   dig_sel    out  4  one-hot digit/column select, active-high
//   seg_data   out  4  nibble of the digit currently being scanned
//   kin        out  4  debounced rows of the column addressed by the last L
//   key_valid  out  1  one-clock pulse when any column's debounced rows change
//
// key_valid carries no handshake. It is a single-cycle event flag. It goes
// high in the clock after the sample that changed a column's debounced rows.
// kin follows one clock after that.

module dg0045_io_scanner #(
  parameter int SCAN_DIV = 1024,
  parameter int BLANK    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nd_n,
  input  logic [3:0] nl_n,
  input  logic [3:0] key_row,
  output logic [3:0] dig_sel,
  output logic [3:0] seg_data,
  output logic [3:0] kin,
  output logic       key_valid
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE);

  // Synchronisers. The third ND flop exists only for edge detection.
  logic       nd_s1, nd_s2, nd_s3;
  logic [3:0] nl_s1, nl_s2;
  logic [3:0] rows_s1, rows_s2;

  logic [3:0]    digit_buf [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    idx;
  logic [PW-1:0] presc;
  // Only bits [1:0] of the last L value are ever used (column select), so only
  // those bits are kept.
  logic [1:0]    l_sel;

  logic [3:0]    cand [4];
  logic [CW-1:0] cnt  [4];
  logic [3:0]    deb  [4];

  logic          capture;
  logic          slot_end;
  logic          same;
  logic [CW-1:0] cnt_next;
  logic          deb_update;

  // ND rises at the end of the core's F2 phase. L is stable by then.
  assign capture  = nd_s2 & ~nd_s3;
  assign slot_end = (presc == PRESC_LAST);

  // Debounce decision for the column that is driven in the current slot.
  always_comb begin
    same       = (rows_s2 == cand[idx]);
    cnt_next   = (cnt[idx] == DEB_MAX) ? DEB_MAX : cnt[idx] + 1'b1;
    deb_update = slot_end && same && (cnt_next == DEB_MAX) &&
                 (rows_s2 != deb[idx]);
  end

  // The digit select is decoded from registers only, so it cannot glitch
  // because of input activity.
  always_comb begin
    dig_sel = 4'b0000;
    if (presc >= BLANK_END) dig_sel[idx] = 1'b1;
  end

  assign seg_data = digit_buf[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      nd_s1     <= 1'b1;
      nd_s2     <= 1'b1;
      nd_s3     <= 1'b1;
      nl_s1     <= 4'hF;
      nl_s2     <= 4'hF;
      rows_s1   <= 4'h0;
      rows_s2   <= 4'h0;
      wr_ptr    <= 2'd0;
      idx       <= 2'd0;
      presc     <= '0;
      l_sel     <= 2'd0;
      kin       <= 4'h0;
      key_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_buf[i] <= 4'h0;
        cand[i]      <= 4'h0;
        cnt[i]       <= '0;
        deb[i]       <= 4'h0;
      end
    end else begin
      nd_s1   <= nd_n;
      nd_s2   <= nd_s1;
      nd_s3   <= nd_s2;
      nl_s1   <= nl_n;
      nl_s2   <= nl_s1;
      rows_s1 <= key_row;
      rows_s2 <= rows_s1;

      if (capture) begin
        digit_buf[wr_ptr] <= ~nl_s2;
        l_sel             <= ~nl_s2[1:0];
        wr_ptr            <= wr_ptr + 2'd1;
      end

      if (slot_end) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end

      // The column for idx has been driven for the whole slot, so the
      // synchronised rows are settled when they are sampled here.
      if (slot_end) begin
        if (same) begin
          cnt[idx] <= cnt_next;
          if (deb_update) deb[idx] <= rows_s2;
        end else begin
          cand[idx] <= rows_s2;
          cnt[idx]  <= CW'(1);
        end
      end

      key_valid <= deb_update;
      kin       <= deb[l_sel];
    end
  end

endmodule

// File: tb/tb_dg0045_io_scanner.sv
// Testbench for dg0045_io_scanner with SCAN_DIV=16, BLANK=2, DEBOUNCE=3.
// Inputs are driven and outputs are sampled on the falling clock edge.
// The bench reconstructs buffer contents by watching seg_data while each
// digit select is active.

module tb_dg0045_io_scanner;

  localparam int SCAN_DIV = 16;
  localparam int BLANK    = 2;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       nd_n;
  logic [3:0] nl_n;
  logic [3:0] key_row;
  logic [3:0] dig_sel;
  logic [3:0] seg_data;
  logic [3:0] kin;
  logic       key_valid;

  int checks   = 0;
  int failures = 0;

  // Keypad driver state: 0 = idle, 1 = column 2 held at 0100,
  // 2 = column 2 alternates 0100/0000 on successive slot-2 samples.
  int   key_mode   = 0;
  logic alt_phase  = 1'b0;
  logic prev_dig2  = 1'b0;
  int   slot2_ends = 0;
  int   kv_count   = 0;

  typedef struct {
    logic [3:0]  l;
    logic [15:0] exp_buf;  // {buf3, buf2, buf1, buf0}
    logic [3:0]  exp_kin;
  } vec_t;

  vec_t vecs[6];

  dg0045_io_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK    (BLANK),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .nd_n      (nd_n),
    .nl_n      (nl_n),
    .key_row   (key_row),
    .dig_sel   (dig_sel),
    .seg_data  (seg_data),
    .kin       (kin),
    .key_valid (key_valid)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout actual=none required=event", name);
  endtask

  // One clock: advance to the falling edge, track slot-2 ends, drive the rows.
  task automatic step();
    @(negedge clk);
    if (prev_dig2 && !dig_sel[2]) begin
      slot2_ends++;
      alt_phase = ~alt_phase;
    end
    prev_dig2 = dig_sel[2];
    case (key_mode)
      1:       key_row = dig_sel[2] ? 4'b0100 : 4'b0000;
      2:       key_row = (dig_sel[2] && alt_phase) ? 4'b0100 : 4'b0000;
      default: key_row = 4'b0000;
    endcase
    if (key_valid) kv_count++;
  endtask

  task automatic strobe(input logic [3:0] l);
    nl_n = ~l;
    step();
    nd_n = 1'b0;
    step();
    step();
    nd_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic wait_slot2_end();
    int start;
    bit seen;
    start = slot2_ends;
    seen  = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (slot2_ends != start) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) fail_timeout("slot2_end");
  endtask

  task automatic wait_dig(input logic [3:0] val);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (dig_sel == val) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) fail_timeout($sformatf("wait_dig_%b", val));
  endtask

  // Record seg_data for each active digit select and compare it with exp.
  task automatic check_buf(input string tag, input logic [15:0] exp);
    logic [3:0] got [4];
    logic [3:0] seen;
    int         j;
    seen = 4'h0;
    for (int k = 0; k < 4; k++) got[k] = 4'h0;
    for (int n = 0; n < 120 && seen != 4'hF; n++) begin
      step();
      case (dig_sel)
        4'b0001: j = 0;
        4'b0010: j = 1;
        4'b0100: j = 2;
        4'b1000: j = 3;
        default: j = -1;
      endcase
      if (j >= 0) begin
        got[j]  = seg_data;
        seen[j] = 1'b1;
      end
    end
    if (seen != 4'hF) fail_timeout({tag, "_scan"});
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_buf%0d", tag, k), 16'(got[k]), 16'(exp[k*4 +: 4]));
  endtask

  initial begin
    int zeros;
    int ones;
    int kvb;
    bit ok;

    vecs[0] = '{l: 4'h5, exp_buf: 16'h0005, exp_kin: 4'h0};
    vecs[1] = '{l: 4'hA, exp_buf: 16'h00A5, exp_kin: 4'h0};
    vecs[2] = '{l: 4'h3, exp_buf: 16'h03A5, exp_kin: 4'h0};
    vecs[3] = '{l: 4'hC, exp_buf: 16'hC3A5, exp_kin: 4'h0};
    vecs[4] = '{l: 4'h7, exp_buf: 16'hC3A7, exp_kin: 4'h0};
    vecs[5] = '{l: 4'h2, exp_buf: 16'hC327, exp_kin: 4'h0};

    // Reset
    rst     = 1'b1;
    nd_n    = 1'b1;
    nl_n    = 4'hF;
    key_row = 4'h0;
    repeat (3) step();
    check("rst_dig_sel", 16'(dig_sel), 16'h0);
    check("rst_seg_data", 16'(seg_data), 16'h0);
    check("rst_kin", 16'(kin), 16'h0);
    check("rst_key_valid", 16'(key_valid), 16'h0);
    rst = 1'b0;
    step();
    check("blank_after_rst", 16'(dig_sel), 16'h0);

    // Load the buffer
    for (int i = 0; i < 4; i++) begin
      strobe(vecs[i].l);
      check($sformatf("a_kin_v%0d", i), 16'(kin), 16'(vecs[i].exp_kin));
      check_buf($sformatf("a_v%0d", i), vecs[i].exp_buf);
    end

    // Slot 0 blanking and slot length
    wait_dig(4'b1000);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (dig_sel != 4'b1000) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) fail_timeout("slot3_leave");
    zeros = 0;
    for (int n = 0; n < 40 && dig_sel == 4'b0000; n++) begin
      zeros++;
      step();
    end
    check("slot0_blank_len", 16'(zeros), 16'(BLANK));
    check("slot0_dig_sel", 16'(dig_sel), 16'b0001);
    check("slot0_seg_data", 16'(seg_data), 16'h5);
    ones = 0;
    for (int n = 0; n < 40 && dig_sel == 4'b0001; n++) begin
      ones++;
      step();
    end
    check("slot0_active_len", 16'(ones), 16'(SCAN_DIV - BLANK));

    // Mid-scan reset with the buffer loaded
    repeat (5) step();
    rst = 1'b1;
    step();
    step();
    check("midrst_dig_sel", 16'(dig_sel), 16'h0);
    check("midrst_seg_data", 16'(seg_data), 16'h0);
    check("midrst_kin", 16'(kin), 16'h0);
    check("midrst_key_valid", 16'(key_valid), 16'h0);
    rst = 1'b0;
    check_buf("midrst", 16'h0000);

    // Reset after ND rises but before the capture edge
    nl_n = ~4'hE;
    step();
    nd_n = 1'b0;
    step();
    step();
    nd_n = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    check_buf("capabort", 16'h0000);

    // Reload the buffer, then wrap the write pointer
    for (int i = 0; i < 6; i++) begin
      strobe(vecs[i].l);
      check($sformatf("b_kin_v%0d", i), 16'(kin), 16'(vecs[i].exp_kin));
      check_buf($sformatf("b_v%0d", i), vecs[i].exp_buf);
    end

    // Alternating rows on column 2 never become stable
    key_mode = 0;
    wait_slot2_end();
    key_mode  = 2;
    alt_phase = 1'b1;
    kvb = kv_count;
    repeat (6) wait_slot2_end();
    step();
    step();
    check("alt_kin", 16'(kin), 16'h0);
    check("alt_key_valid_cnt", 16'(kv_count - kvb), 16'd0);
    key_mode = 0;
    wait_slot2_end();

    // Column 2 held: the third sample commits the new rows
    key_mode = 1;
    kvb = kv_count;
    wait_slot2_end();
    wait_slot2_end();
    step();
    step();
    check("hold2_kin", 16'(kin), 16'h0);
    check("hold2_key_valid_cnt", 16'(kv_count - kvb), 16'd0);
    wait_slot2_end();
    check("hold3_key_valid", 16'(key_valid), 16'h1);
    step();
    check("hold3_key_valid_drop", 16'(key_valid), 16'h0);
    step();
    check("hold3_kin", 16'(kin), 16'b0100);
    check("hold3_key_valid_cnt", 16'(kv_count - kvb), 16'd1);
    wait_slot2_end();
    wait_slot2_end();
    step();
    check("held_kin", 16'(kin), 16'b0100);
    check("held_key_valid_cnt", 16'(kv_count - kvb), 16'd1);

    // L_last selects column 1, which has no key pressed
    strobe(4'h1);
    check("col1_kin", 16'(kin), 16'h0);
    check_buf("col1", 16'hC127);

    // A capture lands on the slot-advance edge and writes buf[idx+1]
    wait_dig(4'b0010);
    wait_dig(4'b0000);
    nl_n = ~4'h9;
    nd_n = 1'b0;
    repeat (13) step();
    nd_n = 1'b1;
    step();
    step();
    check("edge_pre_dig_sel", 16'(dig_sel), 16'b0100);
    check("edge_pre_seg_data", 16'(seg_data), 16'h1);
    step();
    check("edge_post_dig_sel", 16'(dig_sel), 16'h0);
    check("edge_post_seg_data", 16'(seg_data), 16'h9);
    step();
    step();
    check("edge_slot3_dig_sel", 16'(dig_sel), 16'b1000);
    check_buf("edge", 16'h9127);

    // Write pointer has wrapped back to entry 0
    strobe(4'h4);
    check_buf("wrap", 16'h9124);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
